// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store unit with fixed-latency read and sub-word read-modify-write
// Define MEM_ACCESS_ALIGN_CHECK_EN to build misalignment detection (ERR state, misalign pulse).
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_RWAIT, S_WRITE, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RWAIT, S_WRITE, S_DONE} state_t;
`endif

  localparam logic [3:0] LAT4 = 4'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        lu_q, lu_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;
  logic [31:0] rdata_q, rdata_d;

  logic        in_half, in_byte, in_word, mis_in;
  logic        q_half, q_byte, q_word;
  logic [4:0]  byte_sh, half_sh;
  logic [31:0] lane_sh, load_ext, lane_mask, lane_ins, merged;

  assign in_half = (size == 2'b01);
  assign in_byte = (size == 2'b10);
  assign in_word = !in_half && !in_byte;
  assign q_half  = (size_q == 2'b01);
  assign q_byte  = (size_q == 2'b10);
  assign q_word  = !q_half && !q_byte;
  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign mis_in = (in_half && addr[0]) || (in_word && (addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  // Lane extraction works on the word arriving this cycle so rdata is ready on entry to DONE.
  always_comb begin : lane_logic
    lane_sh   = q_half ? (mem_rdata >> half_sh) : (mem_rdata >> byte_sh);
    load_ext  = mem_rdata;
    lane_mask = 32'h0000_0000;
    lane_ins  = 32'h0000_0000;
    if (q_byte) begin
      load_ext  = {{24{~lu_q & lane_sh[7]}}, lane_sh[7:0]};
      lane_mask = 32'h0000_00FF << byte_sh;
      lane_ins  = {24'h00_0000, wdata_q[7:0]} << byte_sh;
    end else if (q_half) begin
      load_ext  = {{16{~lu_q & lane_sh[15]}}, lane_sh[15:0]};
      lane_mask = 32'h0000_FFFF << half_sh;
      lane_ins  = {16'h0000, wdata_q[15:0]} << half_sh;
    end
    merged = q_word ? wdata_q : ((rword_q & ~lane_mask) | lane_ins);
  end

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      lu_q    <= 1'b0;
      wdata_q <= 32'd0;
      rword_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lu_q    <= lu_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    lu_d    = lu_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          we_d    = we;
          size_d  = size;
          lu_d    = load_unsigned;
          wdata_d = wdata;
          if (mis_in) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            state_d = S_ERR;
`endif
          end else if (we && in_word) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RWAIT;
            cnt_d   = LAT4;
          end
        end
      end
      S_RWAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rword_d = mem_rdata;
          if (we_q) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
            rdata_d = load_ext;
          end
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      S_ERR:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wr    = (state_q == S_WRITE);
    mem_wdata = (state_q == S_WRITE) ? merged : 32'd0;
    rdata     = rdata_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misalign  = (state_q == S_ERR);
`else
    misalign  = 1'b0;
`endif
  end

endmodule
